hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It generates the stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazards: load-use data hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses. A watchdog flags memory requests that never complete.

## Interface
Parameters:
- MEM_TIMEOUT, 255: number of MEM_WAIT cycles after which mem_err is set (1..65535).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_rs1_used  in  1  the ID instruction reads rs1.
- id_rs2_used  in  1  the ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX redirects the PC.
- mem_req  in  1  the MEM stage has a data-memory access outstanding.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- idex_stall  out  1  hold ID/EX.
- exmem_stall  out  1  hold EX/MEM.
- ifid_flush  out  1  clear IF/ID to a NOP.
- idex_flush  out  1  clear ID/EX to a bubble.
- mem_err  out  1  sticky flag: a memory access exceeded MEM_TIMEOUT cycles.

## Operation
- All control outputs are combinational from the inputs and the current state. Hazard response applies in the same cycle as detection.
- Define mem_hold = mem_req & ~mem_ready.
- Define load_use = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- Priority is mem_hold, then ex_branch_taken, then load_use.
- When mem_hold is active:
  - pc_stall, ifid_stall, idex_stall and exmem_stall are all 1.
  - Both flushes are 0.
  - A branch in EX is frozen and takes effect once the hold ends.
- When a branch is taken (no mem_hold):
  - ifid_flush = 1 and idex_flush = 1.
  - All stalls are 0.
  - load_use is ignored, because the dependent instruction is discarded.
- When load_use is active (no mem_hold, no branch):
  - pc_stall = 1, ifid_stall = 1, idex_flush = 1, giving exactly one bubble.
  - In LU_BUBBLE, load_use detection is masked, since EX then holds a bubble.
- FSM states (encoded in hazard_pkg):
  - RUN: go to LU_BUBBLE on load_use. Go to MEM_WAIT on mem_hold, which has priority.
  - LU_BUBBLE: lasts one cycle. Go to MEM_WAIT if mem_hold, else RUN.
  - MEM_WAIT: remain while mem_hold. Go to RUN on mem_ready or when mem_req drops.
- Watchdog:
  - A 16-bit counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When the count equals MEM_TIMEOUT, mem_err is set.
  - mem_err is cleared only by reset. The stalls continue while the access is outstanding.

## Timing
- Reset, asynchronous, while rst = 0:
  - state = RUN, watchdog = 0, mem_err = 0.
  - All stall and flush outputs are forced to 0 regardless of inputs.
- Detection-to-control latency is 0 cycles. State updates on the next rising edge.
- A load-use hazard costs exactly 1 cycle. A taken branch costs 2 squashed instructions. A memory hold costs one cycle per cycle that mem_ready stays low.
- mem_req and mem_ready both high in the same cycle: no stall, and no entry to MEM_WAIT.
- Reset asserted mid-MEM_WAIT: the state returns to RUN immediately and the watchdog is cleared.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs stall_cycles [31:0] and flush_count [31:0].
  - stall_cycles increments on each cycle with pc_stall = 1.
  - flush_count increments on each cycle with ifid_flush = 1.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- HAZARD_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- hazard_pkg holds the state enum {RUN, LU_BUBBLE, MEM_WAIT}, the constant REG_ZERO = 5'd0, and the watchdog width constant.
- One sub-module, hazard_perf_cnt, is instantiated only under HAZARD_PERF_EN.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle. The next cycle has all outputs 0.
- Same as the first case but ex_rd=0, or id_rs1_used=0 -> no stall and no flush.
- ex_branch_taken=1 together with a load_use match -> ifid_flush=idex_flush=1 and all stalls 0.
- mem_req=1 and mem_ready=0 for 3 cycles, with ex_branch_taken=1 throughout, then mem_ready=1 -> all four stalls high for 3 cycles with no flush. The next cycle has ifid_flush=idex_flush=1.
- MEM_TIMEOUT=4, mem_req=1 held with mem_ready=0 -> mem_err rises after the 4th MEM_WAIT cycle and stays 1 until rst=0.
- rst pulsed low during MEM_WAIT -> outputs 0 immediately, state RUN, and with HAZARD_PERF_EN defined stall_cycles=0 and flush_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_e : controller state (RUN, LU_BUBBLE, MEM_WAIT)
//   REG_ZERO   : x0 register index; never a real dependency
//   WDOG_W     : width of the memory-access watchdog counter
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      MEM_WAIT  = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         WDOG_W   = 16;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: performance counters for the hazard controller.
//   clk, rst          : core clock, async active-low reset
//   pc_stall          : counted into stall_cycles every cycle it is high
//   ifid_flush        : counted into flush_count every cycle it is high
//   stall_cycles, flush_count : free-running 32-bit counts, wrap mod 2^32
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_stall,
   input  logic        ifid_flush,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (pc_stall)   stall_q <= stall_q + 32'd1;
         if (ifid_flush) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the 5-stage RISC-V pipeline.
// Resolves, in priority order, multi-cycle memory holds, taken branches
// resolved in EX, and load-use hazards. A watchdog sets a sticky mem_err
// when an access stays outstanding for MEM_TIMEOUT cycles in MEM_WAIT.
//   Inputs : clk, rst (async active-low), ID source regs + use flags,
//            EX dest/load/branch info, MEM request/ready handshake.
//   Outputs: pc/ifid/idex/exmem stalls, ifid/idex flushes, mem_err.
// Optional: define HAZARD_PERF_EN to add stall_cycles / flush_count.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idex_stall,
   output logic        exmem_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam logic [WDOG_W-1:0] TIMEOUT_C = WDOG_W'(MEM_TIMEOUT);

   hz_state_e         state_q, state_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              mem_err_q, mem_err_d;

   logic mem_hold, load_use, lu_stall;

   assign mem_hold = mem_req & ~mem_ready;
   assign load_use = ex_mem_read & (ex_rd != REG_ZERO) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd)));
   // EX holds the bubble we just inserted while in LU_BUBBLE, so a stale
   // ex_rd match there must not produce a second bubble.
   assign lu_stall = ~mem_hold & ~ex_branch_taken & load_use &
                     (state_q != LU_BUBBLE);

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      if (rst) begin
         if (mem_hold) begin
            // whole front end freezes, including any taken branch in EX
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
         end else if (lu_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
         end
      end
   end

   // A load-use stall issued on the cycle a memory hold ends also lands
   // in LU_BUBBLE, so every load-use costs exactly one bubble.
   always_comb begin
      state_d = RUN;
      if (mem_hold)      state_d = MEM_WAIT;
      else if (lu_stall) state_d = LU_BUBBLE;
   end

   always_comb begin
      wdog_d    = wdog_q;
      mem_err_d = mem_err_q;
      if (state_q == MEM_WAIT) begin
         // saturate so a very long hold cannot wrap back onto the limit
         if (wdog_q != {WDOG_W{1'b1}}) wdog_d = wdog_q + 1'b1;
         if (wdog_d == TIMEOUT_C)      mem_err_d = 1'b1;
      end else if (mem_hold) begin
         wdog_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         wdog_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wdog_q    <= wdog_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .pc_stall     (pc_stall),
      .ifid_flush   (ifid_flush),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`endif

endmodule
